// File: rtl/pcie_tx_sym_sched.sv
// pcie_tx_sym_sched: frames TLP/DLLP bytes into PCIe TX symbols with round-robin arbitration.
// Define PCIE_SKP_INSERT_EN to add periodic SKP ordered-set insertion between packets.
module pcie_tx_sym_sched #(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_COUNT    = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tlp_req,
  input  logic [7:0] tlp_data,
  input  logic       tlp_last,
  output logic       tlp_ack,
  input  logic       dllp_req,
  input  logic [7:0] dllp_data,
  input  logic       dllp_last,
  output logic       dllp_ack,
  output logic [7:0] txdata,
  output logic       txdatak,
  output logic       skp_active
);
  typedef enum logic [2:0] {
    IDLE, FRAME, BODY, CLOSE
`ifdef PCIE_SKP_INSERT_EN
    , SKP_COM, SKP_SYM
`endif
  } state_t;
  state_t state, state_nx;
  logic rr, rr_nx;
  logic gnt, gnt_nx;
  logic [7:0] sym_nx;
  logic symk_nx;
  logic cur_req, cur_last;
  logic [7:0] cur_data;
`ifdef PCIE_SKP_INSERT_EN
  localparam int CW = $clog2(SKP_INTERVAL);
  localparam logic [CW-1:0] SKP_MAX = CW'(SKP_INTERVAL - 1);
  logic [CW-1:0] skp_cnt;
  logic [2:0] skp_idx;
  logic skp_pend, skp_nx;
`endif
  // rr and gnt: 1 selects DLLP, 0 selects TLP
  assign cur_req  = gnt ? dllp_req : tlp_req;
  assign cur_data = gnt ? dllp_data : tlp_data;
  assign cur_last = gnt ? dllp_last : tlp_last;
  always_comb begin
    state_nx = state;
    rr_nx = rr;
    gnt_nx = gnt;
    sym_nx = 8'h00;
    symk_nx = 1'b0;
    tlp_ack = 1'b0;
    dllp_ack = 1'b0;
`ifdef PCIE_SKP_INSERT_EN
    skp_nx = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef PCIE_SKP_INSERT_EN
        if (skp_pend) state_nx = SKP_COM;
        else
`endif
        if (tlp_req || dllp_req) begin
          gnt_nx = (tlp_req && dllp_req) ? rr : dllp_req;
          state_nx = FRAME;
        end
      end
      FRAME: begin
        sym_nx = gnt ? 8'h5C : 8'hFB;
        symk_nx = 1'b1;
        state_nx = BODY;
      end
      BODY: begin
        tlp_ack = !gnt && tlp_req;
        dllp_ack = gnt && dllp_req;
        if (cur_req) begin
          sym_nx = cur_data;
          state_nx = cur_last ? CLOSE : BODY;
        end else begin
          sym_nx = 8'hFE;
          symk_nx = 1'b1;
          state_nx = IDLE;
          rr_nx = !rr;
        end
      end
      CLOSE: begin
        sym_nx = 8'hFD;
        symk_nx = 1'b1;
        state_nx = IDLE;
        rr_nx = !rr;
      end
`ifdef PCIE_SKP_INSERT_EN
      SKP_COM: begin
        sym_nx = 8'hBC;
        symk_nx = 1'b1;
        skp_nx = 1'b1;
        state_nx = SKP_SYM;
      end
      SKP_SYM: begin
        sym_nx = 8'h1C;
        symk_nx = 1'b1;
        skp_nx = 1'b1;
        state_nx = (skp_idx == 3'(SKP_COUNT - 1)) ? IDLE : SKP_SYM;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr <= 1'b1;
      gnt <= 1'b0;
      txdata <= 8'h00;
      txdatak <= 1'b0;
    end else begin
      state <= state_nx;
      rr <= rr_nx;
      gnt <= gnt_nx;
      txdata <= sym_nx;
      txdatak <= symk_nx;
    end
  end
`ifdef PCIE_SKP_INSERT_EN
  // counter saturates so a long packet cannot wrap it past the pending point
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skp_cnt <= '0;
      skp_pend <= 1'b0;
      skp_idx <= 3'd0;
      skp_active <= 1'b0;
    end else begin
      skp_active <= skp_nx;
      skp_idx <= (state == SKP_SYM) ? skp_idx + 3'd1 : 3'd0;
      if (state == SKP_COM) begin
        skp_cnt <= '0;
        skp_pend <= 1'b0;
      end else if (state != SKP_SYM) begin
        skp_cnt <= (skp_cnt == SKP_MAX) ? skp_cnt : skp_cnt + 1'b1;
        if (skp_cnt == SKP_MAX) skp_pend <= 1'b1;
      end
    end
  end
`else
  assign skp_active = (SKP_INTERVAL < 0) && (SKP_COUNT < 0);
`endif
endmodule

// File: tb/tb_pcie_tx_sym_sched.sv
// tb_pcie_tx_sym_sched: scoreboard bench; packet-level model predicts the framed symbol stream.
module tb_pcie_tx_sym_sched;
`ifdef PCIE_SKP_INSERT_EN
  localparam int SI = 16;
`else
  localparam int SI = 1180;
`endif
  localparam int SC = 3;
  logic clock = 1'b0, reset = 1'b1;
  logic tlp_req = 1'b0, tlp_last = 1'b0, tlp_ack;
  logic dllp_req = 1'b0, dllp_last = 1'b0, dllp_ack;
  logic [7:0] tlp_data = 8'h00, dllp_data = 8'h00, txdata;
  logic txdatak, skp_active;
  always #5 clock = ~clock;
  pcie_tx_sym_sched #(.SKP_INTERVAL(SI), .SKP_COUNT(SC)) dut (
    .clock(clock), .reset(reset),
    .tlp_req(tlp_req), .tlp_data(tlp_data), .tlp_last(tlp_last), .tlp_ack(tlp_ack),
    .dllp_req(dllp_req), .dllp_data(dllp_data), .dllp_last(dllp_last), .dllp_ack(dllp_ack),
    .txdata(txdata), .txdatak(txdatak), .skp_active(skp_active)
  );
  int n_chk = 0, n_fail = 0;
  logic [9:0] tq[$], dq[$];
  logic [8:0] exp_q[$], p_sym[$];
  int p_off[$], p_len[$];
  bit p_src[$];
  int exp_tack, exp_dack, n_tack, n_dack, gap, c;
  bit t_drop, d_drop, mon_en, in_pkt, seen_end, ta, da;
  logic [8:0] s;
`ifdef PCIE_SKP_INSERT_EN
  int ss = 0, n_skp = 0;
`endif
  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction
  // source streams: {drop, last, data}; a drop entry holds req low for one cycle
  task automatic add_pkt(bit src, int len, int drop, bit rnd);
    int n;
    logic [7:0] b;
    logic [9:0] e;
    n = (drop > 0) ? drop : len;
    p_src.push_back(src);
    p_off.push_back(p_sym.size());
    p_len.push_back(n + 2);
    p_sym.push_back(src ? 9'h15C : 9'h1FB);
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom_range(1, 255)) : 8'(i + 1);
      e = {1'b0, (drop <= 0) && (i == len - 1), b};
      if (src) dq.push_back(e); else tq.push_back(e);
      p_sym.push_back({1'b0, b});
    end
    if (drop > 0) begin
      if (src) dq.push_back(10'h200); else tq.push_back(10'h200);
    end
    p_sym.push_back(drop > 0 ? 9'h1FE : 9'h1FD);
    if (src) exp_dack += n; else exp_tack += n;
  endtask
  // arbitration model: DLLP favoured after reset, preference flips after every packet
  task automatic model();
    int ti[$], di[$];
    int p;
    bit ptr, pick;
    ptr = 1'b1;
    foreach (p_src[i]) if (p_src[i]) di.push_back(i); else ti.push_back(i);
    while (ti.size() > 0 || di.size() > 0) begin
      pick = (ti.size() > 0 && di.size() > 0) ? ptr : (di.size() > 0);
      p = pick ? di.pop_front() : ti.pop_front();
      for (int j = 0; j < p_len[p]; j++) exp_q.push_back(p_sym[p_off[p] + j]);
      ptr = !ptr;
    end
  endtask
  task automatic clear_all();
    tq.delete(); dq.delete(); exp_q.delete();
    p_sym.delete(); p_off.delete(); p_len.delete(); p_src.delete();
    t_drop = 1'b0; d_drop = 1'b0;
    n_tack = 0; n_dack = 0; exp_tack = 0; exp_dack = 0;
    in_pkt = 1'b0; seen_end = 1'b0; gap = 0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    mon_en = 1'b0;
    clear_all();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    mon_en = 1'b1;
  endtask
  task automatic run_to_end(int budget);
    int k;
    k = 0;
    while ((exp_q.size() > 0 || tq.size() > 0 || dq.size() > 0) && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (4) @(negedge clock);
    chk("tlp_acks", n_tack, exp_tack);
    chk("dllp_acks", n_dack, exp_dack);
  endtask
  initial begin
    forever begin
      @(negedge clock);
      ta = tlp_ack;
      da = dllp_ack;
      @(posedge clock);
      #1;
      if ((ta || t_drop) && tq.size() > 0) void'(tq.pop_front());
      if ((da || d_drop) && dq.size() > 0) void'(dq.pop_front());
      t_drop = 1'b0;
      d_drop = 1'b0;
      if (tq.size() == 0) begin
        tlp_req = 1'b0; tlp_data = 8'h00; tlp_last = 1'b0;
      end else if (tq[0][9]) begin
        tlp_req = 1'b0; t_drop = 1'b1;
      end else begin
        tlp_req = 1'b1; tlp_data = tq[0][7:0]; tlp_last = tq[0][8];
      end
      if (dq.size() == 0) begin
        dllp_req = 1'b0; dllp_data = 8'h00; dllp_last = 1'b0;
      end else if (dq[0][9]) begin
        dllp_req = 1'b0; d_drop = 1'b1;
      end else begin
        dllp_req = 1'b1; dllp_data = dq[0][7:0]; dllp_last = dq[0][8];
      end
    end
  end
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en && !reset) begin
        s = {txdatak, txdata};
        if (tlp_ack) n_tack++;
        if (dllp_ack) n_dack++;
        chk("ack_excl", {31'd0, tlp_ack & dllp_ack}, 0);
`ifdef PCIE_SKP_INSERT_EN
        if (skp_active) begin
          chk("skp_sym", s, ss == 0 ? 9'h1BC : 9'h11C);
          chk("skp_in_pkt", {31'd0, in_pkt}, 0);
          ss++;
        end else begin
          if (ss > 0) begin
            chk("skp_len", ss, SC + 1);
            n_skp++;
          end
          ss = 0;
        end
`else
        chk("skp_tied", {31'd0, skp_active}, 0);
`endif
        if (!skp_active) begin
          if (s == 9'h000) gap++;
          else begin
            if (exp_q.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_sym: got %0h expected idle at %0t", s, $time);
            end else chk("sym", s, exp_q.pop_front());
            if (s == 9'h1FB || s == 9'h15C) begin
`ifndef PCIE_SKP_INSERT_EN
              if (seen_end) chk("idle_gap", gap, 1);
`endif
              in_pkt = 1'b1;
            end
            if (s == 9'h1FD || s == 9'h1FE) begin
              in_pkt = 1'b0;
              seen_end = 1'b1;
            end
            gap = 0;
          end
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    do_reset();
    repeat (8) begin
      @(negedge clock);
      chk("idle_data", {txdatak, txdata}, 0);
      chk("idle_acks", {tlp_ack, dllp_ack}, 0);
    end
    do_reset();
    add_pkt(1'b0, 3, 0, 1'b0);
    model();
    run_to_end(100);
    do_reset();
    add_pkt(1'b0, 3, 0, 1'b0);
    add_pkt(1'b1, 4, 0, 1'b1);
    model();
    run_to_end(100);
    do_reset();
    add_pkt(1'b0, 3, 2, 1'b0);
    model();
    run_to_end(100);
`ifdef PCIE_SKP_INSERT_EN
    do_reset();
    n_skp = 0;
    repeat (5) add_pkt(1'b0, 20, 0, 1'b1);
    model();
    run_to_end(1000);
    chk("skp_seen", {31'd0, n_skp > 0}, 1);
`endif
    repeat (5) begin
      do_reset();
      repeat ($urandom_range(3, 8)) begin
        int len, drop;
        len = $urandom_range(1, 8);
        drop = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : 0;
        add_pkt(1'($urandom_range(0, 1)), len, drop, 1'b1);
      end
      model();
      run_to_end(2000);
    end
    do_reset();
    add_pkt(1'b0, 8, 0, 1'b1);
    model();
    c = 0;
    while (n_tack < 3 && c < 100) begin
      @(negedge clock);
      c++;
    end
    chk("body_reached", {31'd0, n_tack >= 3}, 1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_txdata", {txdatak, txdata}, 0);
    chk("rst_acks", {tlp_ack, dllp_ack}, 0);
    chk("rst_skp", {31'd0, skp_active}, 0);
    mon_en = 1'b0;
    clear_all();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (6) begin
      @(negedge clock);
      chk("post_rst_idle", {txdatak, txdata}, 0);
      chk("post_rst_acks", {tlp_ack, dllp_ack}, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
